inv_subbytes_seq: RTL and testbench

//  Inverse SubBytes engine for the AES-128 decryption datapath: applies the
//  AES inverse S-box to every byte of a 128-bit state, LANES bytes per cycle,
//  so the lookup hardware is shared. It pairs with the forward S_BOX/SUBWORD

---
 rtl/inv_subbytes_seq.sv | 119 +++++++++++
 tb/tb_inv_subbytes_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/inv_subbytes_seq.sv
// AES inverse SubBytes engine: substitutes LANES bytes of a 128-bit state per
// BUSY cycle through shared inverse S-box lookups, with valid/ready handshakes.
module inv_subbytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] DATA_I,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] DATA_O,
    output logic         BUSY
);

    localparam int unsigned NSTEP = 16 / LANES;
    localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_fsm;
    logic [SW-1:0]   r_step;
    logic [127:0]    r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_busy;

    logic [7:0]      w_lane_in  [LANES];
    logic [7:0]      w_lane_out [LANES];
    logic [127:0]    w_state_sub;

    // Byte b lives at bits [127-8b -: 8]; the current step owns bytes step*LANES upward.
    always_comb begin
        w_state_sub = r_state;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[l]  = r_state[8*(15 - (32'(r_step)*LANES + l)) +: 8];
            w_lane_out[l] = INV_SBOX[w_lane_in[l]];
            w_state_sub[8*(15 - (32'(r_step)*LANES + l)) +: 8] = w_lane_out[l];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fsm       <= S_IDLE;
            r_step      <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_state    <= DATA_I;
                        r_step     <= '0;
                        r_fsm      <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    r_state <= w_state_sub;
                    if (r_step == SW'(NSTEP - 1)) begin
                        r_step      <= '0;
                        r_fsm       <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_step <= r_step + SW'(1);
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_fsm       <= S_IDLE;
                    r_step      <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_out_valid;
    assign BUSY      = r_busy;
    assign DATA_O    = r_state;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Directed bench for inv_subbytes_seq at LANES=4, 1 and 16, including a
// forward S-box round trip on random states.
`timescale 1ns/1ps
module tb_inv_subbytes_seq;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam int LAT [3] = '{4, 16, 1};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];
    logic [127:0] data_i    [3];
    logic [127:0] data_o    [3];

    int n_err    = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    inv_subbytes_seq #(.LANES(4)) u_dut4 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .DATA_I(data_i[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .DATA_O(data_o[0]), .BUSY(busy[0])
    );
    inv_subbytes_seq #(.LANES(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .DATA_I(data_i[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .DATA_O(data_o[1]), .BUSY(busy[1])
    );
    inv_subbytes_seq #(.LANES(16)) u_dut16 (
        .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
        .DATA_I(data_i[2]), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]),
        .DATA_O(data_o[2]), .BUSY(busy[2])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fwd_sub(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[8*(15-b) +: 8] = SBOX[s[8*(15-b) +: 8]];
        return r;
    endfunction

    // Waits for IN_READY, presents one state, returns result and edges from accept to OUT_VALID.
    task automatic send(input int id, input logic [127:0] d, output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready[id] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        in_valid[id] = 1'b1;
        data_i[id]   = d;
        @(posedge clk);
        #1;
        in_valid[id] = 1'b0;
        data_i[id]   = ~d;
        lat = 0;
        while (!out_valid[id] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = data_o[id];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res;
        logic [127:0] st;
        int           lat;
        string        nm;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            data_i[i]    = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_busy", 128'(busy[0]), 128'd0);
        chk("rst_data_o", data_o[0], 128'h0);
        chk("rst_in_ready_l1", 128'(in_ready[1]), 128'd1);
        chk("rst_in_ready_l16", 128'(in_ready[2]), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send(0, 128'h637c777bf26b6fc53001672bfed7ab76, res, lat);
        chk("t1_data", res, 128'h000102030405060708090a0b0c0d0e0f);
        chk("t1_latency", 128'(lat), 128'd4);

        for (int id = 0; id < 3; id++) begin
            nm = $sformatf("t2_zero_l%0d", id);
            send(id, {16{8'h00}}, res, lat);
            chk(nm, res, {16{8'h52}});
            chk({nm, "_lat"}, 128'(lat), 128'(LAT[id]));
            nm = $sformatf("t2_16_l%0d", id);
            send(id, {16{8'h16}}, res, lat);
            chk(nm, res, {16{8'hff}});
            chk({nm, "_lat"}, 128'(lat), 128'(LAT[id]));
        end

        // Backpressure: result must hold in DONE until OUT_READY.
        out_ready[0] = 1'b0;
        send(0, 128'h637c777bf26b6fc53001672bfed7ab76, res, lat);
        chk("t3_lat", 128'(lat), 128'd4);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("t3_hold_valid", 128'(out_valid[0]), 128'd1);
            chk("t3_hold_data", data_o[0], 128'h000102030405060708090a0b0c0d0e0f);
            chk("t3_hold_in_ready", 128'(in_ready[0]), 128'd0);
        end
        @(negedge clk);
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_release_valid", 128'(out_valid[0]), 128'd0);
        chk("t3_release_in_ready", 128'(in_ready[0]), 128'd1);

        // New data offered during BUSY must be ignored.
        @(negedge clk);
        in_valid[0] = 1'b1;
        data_i[0]   = 128'h637c777bf26b6fc53001672bfed7ab76;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_busy_in_ready", 128'(in_ready[0]), 128'd0);
            chk("t4_busy_flag", 128'(busy[0]), 128'd1);
            in_valid[0] = 1'b1;
            data_i[0]   = {16{8'h16}};
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        chk("t4_done_valid", 128'(out_valid[0]), 128'd1);
        chk("t4_done_in_ready", 128'(in_ready[0]), 128'd0);
        chk("t4_data", data_o[0], 128'h000102030405060708090a0b0c0d0e0f);
        @(posedge clk);
        #1;
        chk("t4_back_idle", 128'(in_ready[0]), 128'd1);

        // Reset asserted at BUSY step 2 abandons the operation immediately.
        @(negedge clk);
        in_valid[0] = 1'b1;
        data_i[0]   = {16{8'h16}};
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("t5_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("t5_rst_busy", 128'(busy[0]), 128'd0);
        chk("t5_rst_data", data_o[0], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_partial", 128'(out_valid[0]), 128'd0);
        send(0, {16{8'h00}}, res, lat);
        chk("t5_after_data", res, {16{8'h52}});
        chk("t5_after_lat", 128'(lat), 128'd4);

        for (int i = 0; i < 1000; i++) begin
            st = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(0, fwd_sub(st), res, lat);
            chk("t6_roundtrip", res, st);
            chk("t6_latency", 128'(lat), 128'd4);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
